muu_response_combine: RTL and testbench
=======================================

// Module: muu_response_combine
// PURPOSE
//  Transmit-side counterpart of the request splitter: merges one meta word, an optional 64-bit key and
//  VALUE_WIDTH-wide value words into one 128-bit output frame per response, in the same framing the
//  request path parses (header beat, meta2 beat, key beat, 64-bit value beats).
//  Sits between the processing pipeline and the network TX path.
// PARAMETERS
//  NET_META_WIDTH  64      network metadata echoed in header beat [127:64]
//  VALUE_WIDTH     512     value word width; LANES = VALUE_WIDTH/64 beats per value word
//  USER_BITS       3       user/session id width
//  OPS_META_WIDTH  96      operation metadata width; meta width MW = NET_META_WIDTH+OPS_META_WIDTH+USER_BITS
// PORTS
//  clk             in   1      clock
//  rst_n           in   1      synchronous reset, active-low
//  meta_data       in   MW     [63:0] net_meta, [79:64] vallen, [87:80] keylen, [95:88] peerid,
//                              [127:96] aux32, [143:128] aux16, [151:144] opcode, [162:160] userid
//  meta_valid/ready in/out 1   meta handshake
//  key_data        in   64     key word
//  key_valid/ready in/out 1    key handshake
//  value_data      in   VALUE_WIDTH  value word, lane 0 = [63:0] sent first
//  value_valid/last/ready in/in/out 1  value handshake; last marks final word of a value
//  m_axis_tdata    out  128    output beat
//  m_axis_tuserid  out  USER_BITS  userid of current frame
//  m_axis_tvalid/tlast out 1   output valid / final beat of frame
//  m_axis_tready   in   1      downstream ready
//  err_short       out  1      1-cycle pulse: value_last arrived before vallen beats sent
//  err_long        out  1      1-cycle pulse: vallen exhausted before value_last
// BEHAVIOUR
//  Reset: all valids, readies, tlast, err_* = 0; state IDLE; tdata/tuserid = 0.
//  Output register: loads next beat when !m_axis_tvalid || m_axis_tready; 1 beat/cycle sustained.
//  IDLE: meta_ready=1 when output register free; on meta handshake latch meta, go HDR (meta_ready drops).
//  HDR: emit {net_meta, 16'b0, keylen+vallen (16b), opcode, peerid, 16'b0} as [127:64],[63:48],[47:32],
//    [31:24],[23:16],[15:0]. Sum is 16-bit, wrap-around ignored (keylen<=1 by protocol). -> META2.
//  META2: emit {80'b0, aux16, aux32}; tlast=1 and -> IDLE if keylen==0 && vallen==0; else keylen? KEY : VALUE.
//  KEY: key_ready=1 when output free; emit {64'b0, key_data}; tlast if vallen==0 -> IDLE, else VALUE.
//  VALUE: lane counter 0..LANES-1, beat counter from vallen-1 down; emit {64'b0, lane}; value_ready
//    pulses only with the beat that consumes the last used lane of the word (lane LANES-1, or final beat).
//    tlast on beat with left==0 -> IDLE; value_last on that word ok.
//    left==0 but word lacks value_last: pulse err_long, -> DROP.
//    value_last word consumed with left>0: pulse err_short; behaviour per CONFIGURATION.
//  DROP: value_ready=1, discard words until value_last handshake -> IDLE; no output.
//  Backpressure: no input consumed while output register stalled; tdata stable while tvalid&&!tready.
//  Simultaneous: meta for next frame accepted only in IDLE; never overlaps a frame.
//  Reset mid-frame: frame abandoned, no tlast issued, inputs not consumed in reset cycle.
// CONFIGURATION
//  MUU_RSP_LENGTH_FIXUP_EN defined: on early value_last, enter PAD, emit zero beats until beat count
//    matches header length, tlast on last pad beat (frame length always equals header).
//  Not defined: tlast asserted on the beat consuming the value_last word's last lane; frame truncated.
//  err_short pulses in both builds.
// STRUCTURE
//  muu_ops.vh: OPCODE_* constants, meta field offsets (META_VALLEN_LSB etc.), LANES localparam macro.
//  One sub-module: muu_rsp_lane_sel (VALUE_WIDTH word + lane index -> 64-bit lane, combinational mux).
// TESTING
//  T1 meta keylen=0 vallen=0 opcode=0x01 -> 2 beats, hdr[47:32]=0, tlast on beat 2, 1 meta consumed.
//  T2 keylen=1 vallen=8 key=0xDEAD, 1 value word lanes 0..7 -> 11 beats, hdr len=9, lanes in order, tlast beat 11.
//  T3 vallen=10, 2 value words (last on 2nd) -> 13 beats, 2nd word consumed after lane 1, tlast ok, no err.
//  T4 vallen=16, value_last on 1st word -> err_short; FIXUP_EN: 19 beats, last 8 zero; else 11 beats.
//  T5 vallen=4, word without last then word with last -> 7 beats, err_long, both words consumed, back to IDLE.
//  T6 random m_axis_tready (50%) over 100 frames -> beat sequence identical to tready=1 run, tdata stable on stall.

Source files
------------

// File: rtl/muu_response_combine_pkg.sv
// Shared definitions for the response combiner: meta field offsets, FSM states, beat builders.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package muu_response_combine_pkg;

    // Bit offsets of the fields packed into the meta word
    localparam int META_VALLEN_LSB = 64;
    localparam int META_KEYLEN_LSB = 80;
    localparam int META_PEERID_LSB = 88;
    localparam int META_AUX32_LSB  = 96;
    localparam int META_AUX16_LSB  = 128;
    localparam int META_OPCODE_LSB = 144;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_META2,
        ST_KEY,
        ST_VALUE,
        ST_DROP,
        ST_PAD
    } state_t;

    // Fields of the meta word that the frame builder needs after the handshake
    typedef struct packed {
        logic [63:0] net_meta;
        logic [15:0] vallen;
        logic [7:0]  keylen;
        logic [7:0]  peerid;
        logic [31:0] aux32;
        logic [15:0] aux16;
        logic [7:0]  opcode;
    } meta_t;

    // Index width for a lane counter; never below one bit
    function automatic int lane_bits(input int lanes);
        return (lanes > 1) ? $clog2(lanes) : 1;
    endfunction

    // Header beat: length field is keylen+vallen, 16-bit wrap ignored (keylen is 0 or 1)
    function automatic logic [127:0] hdr_beat(input meta_t m);
        logic [15:0] len;
        len = {8'h00, m.keylen} + m.vallen;
        return {m.net_meta, 16'h0000, len, m.opcode, m.peerid, 16'h0000};
    endfunction

    function automatic logic [127:0] meta2_beat(input meta_t m);
        return {80'h0, m.aux16, m.aux32};
    endfunction

endpackage

// File: rtl/muu_rsp_lane_sel.sv
// Picks one 64-bit lane out of a value word; lane 0 is the least significant.
// Latency: combinational.
// Backpressure: none, pure mux.
module muu_rsp_lane_sel
    import muu_response_combine_pkg::*;
#(
    parameter int VALUE_WIDTH = 512,
    parameter int LANE_W      = lane_bits(VALUE_WIDTH / 64)
) (
    input  logic [VALUE_WIDTH-1:0] word,
    input  logic [LANE_W-1:0]      lane,
    output logic [63:0]            lane_data
);
    localparam int LANES = VALUE_WIDTH / 64;

    logic [63:0] lane_words [LANES];

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign lane_words[i] = word[i*64 +: 64];
    end

    assign lane_data = lane_words[lane];

endmodule

// File: rtl/muu_response_combine.sv
// Merges meta, optional key and value words into one 128-bit frame (hdr, meta2, key, value beats).
// Latency: first beat 2 cycles after meta handshake, then 1 beat/cycle.
// Backpressure: nothing consumed while output register stalled; MUU_RSP_LENGTH_FIXUP_EN pads short values.
module muu_response_combine
    import muu_response_combine_pkg::*;
#(
    parameter int NET_META_WIDTH = 64,
    parameter int VALUE_WIDTH    = 512,
    parameter int USER_BITS      = 3,
    parameter int OPS_META_WIDTH = 96
) (
    input  logic                                             clk,
    input  logic                                             rst_n,
    input  logic [NET_META_WIDTH+OPS_META_WIDTH+USER_BITS-1:0] meta_data,
    input  logic                                             meta_valid,
    output logic                                             meta_ready,
    input  logic [63:0]                                      key_data,
    input  logic                                             key_valid,
    output logic                                             key_ready,
    input  logic [VALUE_WIDTH-1:0]                           value_data,
    input  logic                                             value_valid,
    input  logic                                             value_last,
    output logic                                             value_ready,
    output logic [127:0]                                     m_axis_tdata,
    output logic [USER_BITS-1:0]                             m_axis_tuserid,
    output logic                                             m_axis_tvalid,
    output logic                                             m_axis_tlast,
    input  logic                                             m_axis_tready,
    output logic                                             err_short,
    output logic                                             err_long
);
    localparam int LANES   = VALUE_WIDTH / 64;
    localparam int LANE_W  = lane_bits(LANES);
    localparam int UID_LSB = NET_META_WIDTH + OPS_META_WIDTH;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);

    state_t               state;
    meta_t                meta_q;
    meta_t                meta_in;
    logic [USER_BITS-1:0] uid_q;
    logic [LANE_W-1:0]    lane;
    logic [15:0]          left;      // value beats still to send after the current one
    logic [63:0]          lane_data;
    logic                 out_free;
    logic [UID_LSB-META_OPCODE_LSB-9:0] unused_meta_bits;

    assign out_free = !m_axis_tvalid || m_axis_tready;

    assign meta_in = '{
        net_meta: meta_data[63:0],
        vallen:   meta_data[META_VALLEN_LSB +: 16],
        keylen:   meta_data[META_KEYLEN_LSB +: 8],
        peerid:   meta_data[META_PEERID_LSB +: 8],
        aux32:    meta_data[META_AUX32_LSB +: 32],
        aux16:    meta_data[META_AUX16_LSB +: 16],
        opcode:   meta_data[META_OPCODE_LSB +: 8]
    };
    assign unused_meta_bits = meta_data[UID_LSB-1 : META_OPCODE_LSB+8];

    // Readies depend on the live output-register state, so they cannot be registered;
    // gating with rst_n keeps every input untouched during the reset cycle.
    assign meta_ready  = rst_n && out_free && (state == ST_IDLE);
    assign key_ready   = rst_n && out_free && (state == ST_KEY);
    assign value_ready = rst_n && ((state == ST_DROP) ||
                         ((state == ST_VALUE) && out_free && ((lane == LAST_LANE) || (left == 16'd0))));

    muu_rsp_lane_sel #(
        .VALUE_WIDTH (VALUE_WIDTH),
        .LANE_W      (LANE_W)
    ) u_lane_sel (
        .word      (value_data),
        .lane      (lane),
        .lane_data (lane_data)
    );

    // Frame sequencer and output register; a new beat loads only when the register is free
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            meta_q         <= '0;
            uid_q          <= '0;
            lane           <= '0;
            left           <= '0;
            m_axis_tdata   <= '0;
            m_axis_tuserid <= '0;
            m_axis_tvalid  <= 1'b0;
            m_axis_tlast   <= 1'b0;
            err_short      <= 1'b0;
            err_long       <= 1'b0;
        end else begin
            err_short <= 1'b0;
            err_long  <= 1'b0;
            if (out_free) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (meta_valid && meta_ready) begin
                        meta_q <= meta_in;
                        uid_q  <= meta_data[UID_LSB +: USER_BITS];
                        state  <= ST_HDR;
                    end
                end
                ST_HDR: begin
                    if (out_free) begin
                        m_axis_tdata   <= hdr_beat(meta_q);
                        m_axis_tuserid <= uid_q;
                        m_axis_tvalid  <= 1'b1;
                        state          <= ST_META2;
                    end
                end
                ST_META2: begin
                    if (out_free) begin
                        m_axis_tdata  <= meta2_beat(meta_q);
                        m_axis_tvalid <= 1'b1;
                        lane          <= '0;
                        left          <= meta_q.vallen - 16'd1;
                        if ((meta_q.keylen == 8'd0) && (meta_q.vallen == 16'd0)) begin
                            m_axis_tlast <= 1'b1;
                            state        <= ST_IDLE;
                        end else if (meta_q.keylen != 8'd0) begin
                            state <= ST_KEY;
                        end else begin
                            state <= ST_VALUE;
                        end
                    end
                end
                ST_KEY: begin
                    if (key_valid && key_ready) begin
                        m_axis_tdata  <= {64'h0, key_data};
                        m_axis_tvalid <= 1'b1;
                        if (meta_q.vallen == 16'd0) begin
                            m_axis_tlast <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            state <= ST_VALUE;
                        end
                    end
                end
                ST_VALUE: begin
                    if (value_valid && out_free) begin
                        m_axis_tdata  <= {64'h0, lane_data};
                        m_axis_tvalid <= 1'b1;
                        lane          <= (lane == LAST_LANE) ? '0 : lane + 1'b1;
                        if (left == 16'd0) begin
                            // Header length reached: frame ends here whatever the source says
                            m_axis_tlast <= 1'b1;
                            if (value_last) begin
                                state <= ST_IDLE;
                            end else begin
                                err_long <= 1'b1;
                                state    <= ST_DROP;
                            end
                        end else if ((lane == LAST_LANE) && value_last) begin
                            err_short <= 1'b1;
`ifdef MUU_RSP_LENGTH_FIXUP_EN
                            left  <= left - 16'd1;
                            state <= ST_PAD;
`else
                            m_axis_tlast <= 1'b1;
                            state        <= ST_IDLE;
`endif
                        end else begin
                            left <= left - 16'd1;
                        end
                    end
                end
                ST_DROP: begin
                    if (value_valid && value_last) begin
                        state <= ST_IDLE;
                    end
                end
                ST_PAD: begin
                    if (out_free) begin
                        m_axis_tdata  <= '0;
                        m_axis_tvalid <= 1'b1;
                        if (left == 16'd0) begin
                            m_axis_tlast <= 1'b1;
                            state        <= ST_IDLE;
                        end else begin
                            left <= left - 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muu_response_combine.sv
// Bench for muu_response_combine: scoreboard of expected beats, per-scenario tasks.
// Inputs change 1 ns after posedge; outputs and handshakes are sampled on negedge.
// Random output backpressure in the last scenario.
`timescale 1ns/1ps
module tb_muu_response_combine;

    localparam int MW = 163;

    typedef struct packed {
        logic [127:0] d;
        logic         last;
        logic [2:0]   uid;
    } beat_t;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [MW-1:0]  meta_data;
    logic           meta_valid;
    logic           meta_ready;
    logic [63:0]    key_data;
    logic           key_valid;
    logic           key_ready;
    logic [511:0]   value_data;
    logic           value_valid;
    logic           value_last;
    logic           value_ready;
    logic [127:0]   m_axis_tdata;
    logic [2:0]     m_axis_tuserid;
    logic           m_axis_tvalid;
    logic           m_axis_tlast;
    logic           m_axis_tready;
    logic           err_short;
    logic           err_long;

    always #5 clk = ~clk;

    muu_response_combine dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .meta_data      (meta_data),
        .meta_valid     (meta_valid),
        .meta_ready     (meta_ready),
        .key_data       (key_data),
        .key_valid      (key_valid),
        .key_ready      (key_ready),
        .value_data     (value_data),
        .value_valid    (value_valid),
        .value_last     (value_last),
        .value_ready    (value_ready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tuserid (m_axis_tuserid),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tready  (m_axis_tready),
        .err_short      (err_short),
        .err_long       (err_long)
    );

    int     errors = 0;
    int     checks = 0;
    beat_t  sb[$];
    beat_t  exp_b;
    int     beats_seen = 0;
    int     meta_hs = 0;
    int     word_hs = 0;
    int     short_cnt = 0;
    int     long_cnt = 0;
    bit     rand_ready = 1'b0;

    // Value words of the frame being driven
    logic [511:0] wdat [8];
    bit           wlast [8];
    int           nwords = 0;

    logic [127:0] stall_d;
    logic         stall_l;
    bit           stalled = 1'b0;

    // Output backpressure source
    initial begin
        m_axis_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: scoreboard compare, stall stability, handshake and error-pulse counters
    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                checks++;
                if (!(m_axis_tvalid === 1'b1 && m_axis_tdata === stall_d && m_axis_tlast === stall_l)) begin
                    errors++;
                    $display("FAIL stall_hold: tvalid=%b tdata=%h tlast=%b, required tvalid=1 tdata=%h tlast=%b",
                             m_axis_tvalid, m_axis_tdata, m_axis_tlast, stall_d, stall_l);
                end
            end
            stalled = m_axis_tvalid && !m_axis_tready;
            stall_d = m_axis_tdata;
            stall_l = m_axis_tlast;
            if (m_axis_tvalid && m_axis_tready) begin
                beats_seen++;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: tdata=%h tlast=%b, required no beat", m_axis_tdata, m_axis_tlast);
                end else begin
                    exp_b = sb.pop_front();
                    if (m_axis_tdata !== exp_b.d || m_axis_tlast !== exp_b.last || m_axis_tuserid !== exp_b.uid) begin
                        errors++;
                        $display("FAIL beat: tdata=%h tlast=%b uid=%0d, required tdata=%h tlast=%b uid=%0d",
                                 m_axis_tdata, m_axis_tlast, m_axis_tuserid, exp_b.d, exp_b.last, exp_b.uid);
                    end
                end
            end
            if (meta_valid && meta_ready) meta_hs++;
            if (value_valid && value_ready) word_hs++;
            if (err_short) short_cnt++;
            if (err_long) long_cnt++;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [MW-1:0] mk_meta(input logic [63:0] net, input logic [15:0] vl,
                                              input logic [7:0] kl, input logic [7:0] peer,
                                              input logic [31:0] a32, input logic [15:0] a16,
                                              input logic [7:0] op, input logic [2:0] uid);
        logic [MW-1:0] m;
        m = '0;
        m[63:0]    = net;
        m[79:64]   = vl;
        m[87:80]   = kl;
        m[95:88]   = peer;
        m[127:96]  = a32;
        m[143:128] = a16;
        m[151:144] = op;
        m[159:152] = 8'hA5;
        m[162:160] = uid;
        return m;
    endfunction

    task automatic push_beat(input logic [127:0] d, input logic last, input logic [2:0] uid);
        beat_t b;
        b.d = d;
        b.last = last;
        b.uid = uid;
        sb.push_back(b);
    endtask

    task automatic fill_words(input int n);
        nwords = n;
        for (int w = 0; w < 8; w++) begin
            for (int l = 0; l < 8; l++) wdat[w][l*64 +: 64] = {$urandom, $urandom};
            wlast[w] = (w == n - 1);
        end
    endtask

    task automatic drive_meta(input logic [MW-1:0] m);
        int t;
        meta_data = m;
        meta_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!meta_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!meta_ready) begin
            errors++;
            $display("FAIL meta_timeout: meta_ready=0 after %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        meta_valid = 1'b0;
    endtask

    task automatic drive_key(input logic [63:0] k);
        int t;
        key_data = k;
        key_valid = 1'b1;
        t = 0;
        @(negedge clk);
        while (!key_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (!key_ready) begin
            errors++;
            $display("FAIL key_timeout: key_ready=0 after %0d cycles, required 1", t);
        end
        @(posedge clk);
        #1;
        key_valid = 1'b0;
    endtask

    task automatic drive_values();
        int t;
        for (int w = 0; w < nwords; w++) begin
            value_data = wdat[w];
            value_last = wlast[w];
            value_valid = 1'b1;
            t = 0;
            @(negedge clk);
            while (!value_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            checks++;
            if (!value_ready) begin
                errors++;
                $display("FAIL value_timeout: word %0d value_ready=0 after %0d cycles, required 1", w, t);
            end
            @(posedge clk);
            #1;
        end
        value_valid = 1'b0;
        value_last = 1'b0;
    endtask

    // Builds the expected frame into the scoreboard, drives all three streams, waits for the frame to drain
    task automatic run_frame(input logic [15:0] vl, input logic [7:0] kl, input logic [7:0] op,
                             input logic [2:0] uid, input logic [63:0] key, output int nbeats);
        logic [63:0]  net;
        logic [7:0]   peer;
        logic [31:0]  a32;
        logic [15:0]  a16;
        logic [15:0]  len;
        int           vli;
        int           sent;
        int           t;
        bit           done;
        net  = {$urandom, $urandom};
        peer = 8'($urandom);
        a32  = $urandom;
        a16  = 16'($urandom);
        len  = {8'h00, kl} + vl;
        vli  = int'(vl);
        nbeats = 2;
        push_beat({net, 16'h0000, len, op, peer, 16'h0000}, 1'b0, uid);
        push_beat({80'h0, a16, a32}, (kl == 8'd0) && (vl == 16'd0), uid);
        if (kl != 8'd0) begin
            push_beat({64'h0, key}, vl == 16'd0, uid);
            nbeats++;
        end
        sent = 0;
        done = (vli == 0);
        for (int w = 0; w < nwords && !done; w++) begin
            for (int l = 0; l < 8 && !done; l++) begin
                sent++;
                nbeats++;
                if (sent == vli) begin
                    push_beat({64'h0, wdat[w][l*64 +: 64]}, 1'b1, uid);
                    done = 1'b1;
                end else if (l == 7 && wlast[w]) begin
                    done = 1'b1;
`ifdef MUU_RSP_LENGTH_FIXUP_EN
                    push_beat({64'h0, wdat[w][l*64 +: 64]}, 1'b0, uid);
                    for (int p = sent + 1; p <= vli; p++) begin
                        push_beat(128'h0, p == vli, uid);
                        nbeats++;
                    end
`else
                    push_beat({64'h0, wdat[w][l*64 +: 64]}, 1'b1, uid);
`endif
                end else begin
                    push_beat({64'h0, wdat[w][l*64 +: 64]}, 1'b0, uid);
                end
            end
        end
        fork
            drive_meta(mk_meta(net, vl, kl, peer, a32, a16, op, uid));
            begin
                if (kl != 8'd0) drive_key(key);
            end
            drive_values();
        join
        t = 0;
        while (sb.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL frame_drain: %0d beats outstanding, required 0", sb.size());
            sb.delete();
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        meta_data = '0;
        meta_valid = 1'b1;
        key_data = '0;
        key_valid = 1'b1;
        value_data = '0;
        value_valid = 1'b1;
        value_last = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid: tvalid=%b tlast=%b, required 0 0", m_axis_tvalid, m_axis_tlast);
        end
        checks++;
        if (m_axis_tdata !== 128'h0 || m_axis_tuserid !== 3'd0) begin
            errors++;
            $display("FAIL reset_data: tdata=%h uid=%0d, required 0 0", m_axis_tdata, m_axis_tuserid);
        end
        checks++;
        if (err_short !== 1'b0 || err_long !== 1'b0) begin
            errors++;
            $display("FAIL reset_err: short=%b long=%b, required 0 0", err_short, err_long);
        end
        checks++;
        if (meta_ready !== 1'b0 || key_ready !== 1'b0 || value_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: meta=%b key=%b value=%b, required 0 0 0", meta_ready, key_ready, value_ready);
        end
        meta_valid = 1'b0;
        key_valid = 1'b0;
        value_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (meta_ready !== 1'b1 || key_ready !== 1'b0 || value_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_ready: meta=%b key=%b value=%b, required 1 0 0", meta_ready, key_ready, value_ready);
        end
    endtask

    task automatic test_empty_frame();
        int b0, m0, s0, l0, nb;
        b0 = beats_seen; m0 = meta_hs; s0 = short_cnt; l0 = long_cnt;
        fill_words(0);
        run_frame(16'd0, 8'd0, 8'h01, 3'd2, 64'h0, nb);
        checks++;
        if (beats_seen - b0 !== 2) begin
            errors++;
            $display("FAIL empty_beats: got %0d, required 2", beats_seen - b0);
        end
        checks++;
        if (meta_hs - m0 !== 1) begin
            errors++;
            $display("FAIL empty_meta_consumed: got %0d, required 1", meta_hs - m0);
        end
        checks++;
        if (short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin
            errors++;
            $display("FAIL empty_err: short=%0d long=%0d, required 0 0", short_cnt - s0, long_cnt - l0);
        end
    endtask

    task automatic test_key_value();
        int b0, w0, s0, l0, nb;
        b0 = beats_seen; w0 = word_hs; s0 = short_cnt; l0 = long_cnt;
        fill_words(1);
        run_frame(16'd8, 8'd1, 8'h02, 3'd5, 64'hDEAD, nb);
        checks++;
        if (beats_seen - b0 !== 11) begin
            errors++;
            $display("FAIL kv_beats: got %0d, required 11", beats_seen - b0);
        end
        checks++;
        if (word_hs - w0 !== 1 || short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin
            errors++;
            $display("FAIL kv_words_err: words=%0d short=%0d long=%0d, required 1 0 0",
                     word_hs - w0, short_cnt - s0, long_cnt - l0);
        end
    endtask

    task automatic test_two_words();
        int b0, w0, s0, l0, nb;
        b0 = beats_seen; w0 = word_hs; s0 = short_cnt; l0 = long_cnt;
        fill_words(2);
        run_frame(16'd10, 8'd1, 8'h01, 3'd1, 64'h1234_5678_9ABC_DEF0, nb);
        checks++;
        if (beats_seen - b0 !== 13) begin
            errors++;
            $display("FAIL two_words_beats: got %0d, required 13", beats_seen - b0);
        end
        checks++;
        if (word_hs - w0 !== 2 || short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin
            errors++;
            $display("FAIL two_words_err: words=%0d short=%0d long=%0d, required 2 0 0",
                     word_hs - w0, short_cnt - s0, long_cnt - l0);
        end
    endtask

    task automatic test_short_value();
        int b0, w0, s0, l0, nb, want;
`ifdef MUU_RSP_LENGTH_FIXUP_EN
        want = 19;
`else
        want = 11;
`endif
        b0 = beats_seen; w0 = word_hs; s0 = short_cnt; l0 = long_cnt;
        fill_words(1);
        run_frame(16'd16, 8'd1, 8'h03, 3'd6, 64'hCAFE, nb);
        checks++;
        if (beats_seen - b0 !== want) begin
            errors++;
            $display("FAIL short_beats: got %0d, required %0d", beats_seen - b0, want);
        end
        checks++;
        if (short_cnt - s0 !== 1 || long_cnt - l0 !== 0 || word_hs - w0 !== 1) begin
            errors++;
            $display("FAIL short_err: short=%0d long=%0d words=%0d, required 1 0 1",
                     short_cnt - s0, long_cnt - l0, word_hs - w0);
        end
    endtask

    task automatic test_long_value();
        int b0, w0, s0, l0, nb;
        b0 = beats_seen; w0 = word_hs; s0 = short_cnt; l0 = long_cnt;
        fill_words(2);
        run_frame(16'd4, 8'd1, 8'h02, 3'd3, 64'hBEEF, nb);
        checks++;
        if (beats_seen - b0 !== 7) begin
            errors++;
            $display("FAIL long_beats: got %0d, required 7", beats_seen - b0);
        end
        checks++;
        if (long_cnt - l0 !== 1 || short_cnt - s0 !== 0 || word_hs - w0 !== 2) begin
            errors++;
            $display("FAIL long_err: long=%0d short=%0d words=%0d, required 1 0 2",
                     long_cnt - l0, short_cnt - s0, word_hs - w0);
        end
        checks++;
        if (meta_ready !== 1'b1) begin
            errors++;
            $display("FAIL long_back_to_idle: meta_ready=%b, required 1", meta_ready);
        end
    endtask

    task automatic test_random_backpressure();
        int b0, s0, l0, nb, total;
        logic [15:0] vl;
        logic [7:0]  kl;
        b0 = beats_seen; s0 = short_cnt; l0 = long_cnt;
        total = 0;
        rand_ready = 1'b1;
        for (int f = 0; f < 100; f++) begin
            kl = 8'($urandom_range(0, 1));
            vl = 16'($urandom_range(0, 24));
            fill_words((int'(vl) + 7) / 8);
            run_frame(vl, kl, 8'($urandom), 3'($urandom), {$urandom, $urandom}, nb);
            total += nb;
        end
        rand_ready = 1'b0;
        checks++;
        if (beats_seen - b0 !== total) begin
            errors++;
            $display("FAIL random_beats: got %0d, required %0d", beats_seen - b0, total);
        end
        checks++;
        if (short_cnt - s0 !== 0 || long_cnt - l0 !== 0) begin
            errors++;
            $display("FAIL random_err: short=%0d long=%0d, required 0 0", short_cnt - s0, long_cnt - l0);
        end
    endtask

    initial begin
        test_reset();
        test_empty_frame();
        test_key_value();
        test_two_words();
        test_short_value();
        test_long_value();
        test_random_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
